pc_fetch_ctrl: RTL
==================

// Module: pc_fetch_ctrl
// PURPOSE
//  Owns the program counter and sequences instruction fetch for the RV32I core.
//  Selects the next PC: sequential PC+4, branch/jump target (ALUResult when PCsrc=1), or trap vector.
//  Drives a req/gnt/rvalid instruction-memory port and presents one instruction at a time to decode.
//  Decode accepts each instruction with a valid/ready handshake.
//  Replaces the free-running PC register + PC mux with a stall- and flush-aware sequencer.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset release
//  TRAP_VEC   32'h0000_0100  PC loaded on trap
//  NOP_INSTR  32'h0000_0013  instruction value held while instr_valid=0 (addi x0,x0,0)
// PORTS
//  clk          in   1   core clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  imem_req     out  1   fetch request
//  imem_addr    out  32  fetch address, word aligned
//  imem_gnt     in   1   request accepted this cycle
//  imem_rvalid  in   1   read data valid; earliest 1 cycle after gnt, exactly one per gnt
//  imem_rdata   in   32  fetched instruction
//  instr_valid  out  1   instr/instr_pc hold a live instruction
//  instr        out  32  instruction to decode
//  instr_pc     out  32  address of instr
//  instr_ready  in   1   decode/execute retires instr this cycle
//  PCsrc        in   1   retiring instr redirects; sampled only on instr_valid&&instr_ready
//  ALUResult    in   32  redirect target; bits[1:0] forced to 2'b00
//  trap         in   1   flush + load TRAP_VEC; honoured in any state
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, state=REQ, imem_req=0, instr_valid=0,
//   instr=NOP_INSTR, instr_pc=RESET_PC. imem_req rises in the first clk edge after rst_n=1.
//  States: REQ -> WAIT -> HOLD -> REQ; DRAIN discards a stale response.
//   REQ  : imem_req=1, imem_addr=pc. gnt -> WAIT. Address may change only while ungranted.
//   WAIT : imem_req=0. rvalid -> instr<=rdata, instr_pc<=pc, instr_valid<=1, -> HOLD.
//   HOLD : instr_valid=1, instr/instr_pc stable until instr_ready.
//          On handshake: pc <= PCsrc ? {ALUResult[31:2],2'b00} : pc+4; instr_valid<=0; -> REQ.
//   DRAIN: imem_req=0. Wait for rvalid, drop data, -> REQ.
//  Best-case throughput: 1 instruction per 3 cycles (REQ, WAIT, HOLD), with gnt in the first
//   REQ cycle, rvalid 1 cycle later, and instr_ready high.
//  trap (priority over PCsrc and all handshakes), next-state by current state:
//   REQ without gnt   -> pc<=TRAP_VEC, stay REQ.
//   REQ with gnt      -> pc<=TRAP_VEC, go DRAIN.
//   WAIT, no rvalid   -> pc<=TRAP_VEC, go DRAIN.
//   WAIT with rvalid  -> response dropped, pc<=TRAP_VEC, go REQ.
//   HOLD              -> instr_valid<=0, instr<=NOP_INSTR, pc<=TRAP_VEC, go REQ.
//                        Retirement is cancelled even if instr_ready=1.
//   DRAIN             -> pc<=TRAP_VEC, stay DRAIN; an rvalid in the same cycle still exits to REQ.
//  Arithmetic: pc+4 is 32-bit modular; 32'hFFFF_FFFC wraps to 32'h0000_0000.
//  instr=NOP_INSTR whenever instr_valid=0.
//  imem_rvalid outside WAIT/DRAIN is a protocol error: ignored, state unchanged.
//  Mid-operation reset: everything returns to reset values asynchronously.
//   A pending memory response after release is the memory's responsibility.
// STRUCTURE
//  Shared package riscv_pkg: XLEN, NOP_INSTR, TRAP_VEC default,
//   typedef enum logic [2:0] {REQ, WAIT, HOLD, DRAIN} fetch_state_e.
//  Sub-module next_pc_sel (combinational): picks TRAP_VEC / aligned target / pc+4
//   from {trap, PCsrc&&retire}. Everything else, including the FSM, stays in pc_fetch_ctrl.
// TESTING
//  1 Reset, gnt=1 always, rvalid 1 cycle after gnt, instr_ready=1
//     -> imem_addr 0x0,0x4,0x8; instr_valid every 3rd cycle with matching instr_pc.
//  2 HOLD with instr_ready=0 for 5 cycles -> instr/instr_pc stable, no new imem_req, pc unchanged.
//  3 Retire with PCsrc=1, ALUResult=0x0000_0203 -> next imem_addr=0x0000_0200.
//  4 trap in the cycle after gnt (WAIT), rvalid 2 cycles later -> data dropped,
//     instr_valid stays 0, next imem_addr=0x0000_0100.
//  5 pc=0xFFFF_FFFC retires with PCsrc=0 -> next imem_addr=0x0000_0000.
//  6 rst_n low mid-WAIT -> outputs at reset values the same cycle; first req after release to RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: data width, fetch constants and fetch FSM encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DFLT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VEC_DFLT  = 32'h0000_0100;
  localparam logic [XLEN-1:0] NOP_INSTR_DFLT = 32'h0000_0013;

  typedef enum logic [2:0] {
    REQ   = 3'd0,
    WAIT  = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: trap vector, word-aligned redirect target, or sequential pc+4.
module next_pc_sel
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DFLT
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] target,
  input  logic            trap,
  input  logic            redirect,
  output logic [XLEN-1:0] next_pc
);

  always_comb begin
    next_pc = pc + XLEN'(4);
    if (trap) begin
      next_pc = TRAP_VEC;
    end else if (redirect) begin
      next_pc = target & ~XLEN'(3);
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter owner and instruction-fetch sequencer between imem and decode.
//   state | meaning
//   REQ   | imem_req high at pc, waiting for gnt
//   WAIT  | granted, waiting for rvalid
//   HOLD  | instruction presented to decode until instr_ready
//   DRAIN | discarding a response made stale by a trap
module pc_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DFLT,
  parameter logic [XLEN-1:0] TRAP_VEC  = TRAP_VEC_DFLT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DFLT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            PCsrc,
  input  logic [XLEN-1:0] ALUResult,
  input  logic            trap
);

  fetch_state_e    state_q, state_d;
  logic            started_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;

  logic            req_live;
  logic            gnt_ok;
  logic            retire;
  logic            redirect;
  logic [XLEN-1:0] next_pc;

  // started_q keeps imem_req low during reset and for the release cycle
  assign req_live = (state_q == REQ) && started_q;
  assign gnt_ok   = req_live && imem_gnt;
  assign retire   = (state_q == HOLD) && instr_valid_q && instr_ready && !trap;
  assign redirect = retire && PCsrc;

  next_pc_sel #(
    .TRAP_VEC (TRAP_VEC)
  ) u_next_pc_sel (
    .pc       (pc_q),
    .target   (ALUResult),
    .trap     (trap),
    .redirect (redirect),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= REQ;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ: begin
        if (gnt_ok) state_d = trap ? DRAIN : WAIT;
      end
      WAIT: begin
        if (imem_rvalid)  state_d = trap ? REQ : HOLD;
        else if (trap)    state_d = DRAIN;
      end
      HOLD: begin
        if (trap || retire) state_d = REQ;
      end
      DRAIN: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_comb begin
    imem_req      = req_live;
    imem_addr     = pc_q;
    instr_valid   = instr_valid_q;
    instr         = instr_q;
    instr_pc      = instr_pc_q;

    pc_d          = (trap || retire) ? next_pc : pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    if ((state_q == WAIT) && imem_rvalid && !trap) begin
      instr_d       = imem_rdata;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
    end

    // a trap in HOLD cancels the presented instruction even if decode is ready
    if ((state_q == HOLD) && (trap || retire)) begin
      instr_d       = NOP_INSTR;
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

endmodule
